// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with configurable data width,
// parity and stop bits. It rejects start-bit glitches and reports parity,
// framing, break and overrun conditions. Completed frames land in a
// one-entry holding register drained with a valid/rd_ack handshake.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 clk_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 rd_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = 4;
  localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST      = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 r_rxSync;
  logic                 r_rxPrev;
  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [IW-1:0]        r_bitIdx;
  logic                 r_stopIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parityBit;
  logic                 r_frameErr;

  state_t               w_state;
  logic [CW-1:0]        w_count;
  logic [IW-1:0]        w_bitIdx;
  logic                 w_stopIdx;
  logic [DATA_BITS-1:0] w_shift;
  logic                 w_parityBit;
  logic                 w_frameErr;
  logic                 w_commit;
  logic                 w_fallEdge;
  logic                 w_frameErrFinal;
  logic                 w_parityXor;
  logic                 w_parityErr;
  logic                 w_break;

  assign w_fallEdge = r_rxPrev & ~r_rxSync;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= rx;
      r_rxPrev <= r_rxSync;
    end
  end

  // Bit-timing state register and per-frame accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_bitIdx    <= '0;
      r_stopIdx   <= 1'b0;
      r_shift     <= '0;
      r_parityBit <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_bitIdx    <= w_bitIdx;
      r_stopIdx   <= w_stopIdx;
      r_shift     <= w_shift;
      r_parityBit <= w_parityBit;
      r_frameErr  <= w_frameErr;
    end
  end

  // Next-state logic. The start edge is caught on any clock so short idle
  // gaps are never missed; everything else advances only on clk_en. Data
  // bits shift in from the top so the first (LSB) bit ends up in bit 0.
  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_bitIdx    = r_bitIdx;
    w_stopIdx   = r_stopIdx;
    w_shift     = r_shift;
    w_parityBit = r_parityBit;
    w_frameErr  = r_frameErr;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_count   = '0;
        w_bitIdx  = '0;
        w_stopIdx = 1'b0;
        if (w_fallEdge) begin
          w_state     = S_START;
          w_shift     = '0;
          w_parityBit = 1'b0;
          w_frameErr  = 1'b0;
        end
      end
      S_START: begin
        if (clk_en) begin
          if (r_count == MID && r_rxSync) begin
            w_state = S_IDLE;
            w_count = '0;
          end else if (r_count == LAST) begin
            w_state  = S_DATA;
            w_count  = '0;
            w_bitIdx = '0;
          end else begin
            w_count = r_count + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (clk_en) begin
          if (r_count == MID) begin
            w_shift = {r_rxSync, r_shift[DATA_BITS-1:1]};
          end
          if (r_count == LAST) begin
            w_count = '0;
            if (r_bitIdx == LAST_BIT) begin
              w_bitIdx = '0;
              w_state  = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              w_bitIdx = r_bitIdx + 1'b1;
            end
          end else begin
            w_count = r_count + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (clk_en) begin
          if (r_count == MID) begin
            w_parityBit = r_rxSync;
          end
          if (r_count == LAST) begin
            w_state = S_STOP;
            w_count = '0;
          end else begin
            w_count = r_count + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (clk_en) begin
          if (r_count == MID) begin
            if (!r_rxSync) begin
              w_frameErr = 1'b1;
            end
            if (r_stopIdx == LAST_STOP) begin
              w_commit  = 1'b1;
              w_state   = S_IDLE;
              w_count   = '0;
              w_stopIdx = 1'b0;
            end else begin
              w_count = r_count + 1'b1;
            end
          end else if (r_count == LAST) begin
            w_count   = '0;
            w_stopIdx = r_stopIdx + 1'b1;
          end else begin
            w_count = r_count + 1'b1;
          end
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_count   = '0;
        w_bitIdx  = '0;
        w_stopIdx = 1'b0;
      end
    endcase
  end

  // Frame status as seen on the commit cycle; the final stop sample is
  // folded in directly because it is not yet in r_frameErr.
  always_comb begin
    w_frameErrFinal = r_frameErr | ~r_rxSync;
    w_parityXor     = (^r_shift) ^ r_parityBit;
    w_parityErr     = 1'b0;
    if (PARITY == 1) begin
      w_parityErr = w_parityXor;
    end else if (PARITY == 2) begin
      w_parityErr = ~w_parityXor;
    end
    w_break = w_frameErrFinal && (r_shift == '0) && ((PARITY == 0) || !r_parityBit);
  end

  // Holding register: a commit loads when empty or being drained in the
  // same cycle, otherwise the new frame is dropped and overrun pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_commit) begin
        if (!valid || rd_ack) begin
          data       <= r_shift;
          parity_err <= w_parityErr;
          frame_err  <= w_frameErrFinal;
          break_det  <= w_break;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && rd_ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed tests for uart_rx_frame in four configurations
// (8N1, 8E1, 8O1, 7O2), each with its own serial line and rd_ack.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       clk_en = 1'b0;
  logic [3:0] rx = 4'hF;
  logic [3:0] ack = 4'h0;

  wire [7:0] data0;
  wire [7:0] data1;
  wire [7:0] data2;
  wire [6:0] data3;
  wire [3:0] valid;
  wire [3:0] perr;
  wire [3:0] ferr;
  wire [3:0] brk;
  wire [3:0] ovr;

  int testsRun = 0;
  int testsFailed = 0;
  int tickDiv = 0;
  int validCycles[4];
  int ovrCycles[4];

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u8n1 (
    .clk(clk), .reset_n(reset_n), .rx(rx[0]), .clk_en(clk_en), .data(data0),
    .valid(valid[0]), .rd_ack(ack[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .break_det(brk[0]), .overrun(ovr[0]));

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u8e1 (
    .clk(clk), .reset_n(reset_n), .rx(rx[1]), .clk_en(clk_en), .data(data1),
    .valid(valid[1]), .rd_ack(ack[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .break_det(brk[1]), .overrun(ovr[1]));

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u8o1 (
    .clk(clk), .reset_n(reset_n), .rx(rx[2]), .clk_en(clk_en), .data(data2),
    .valid(valid[2]), .rd_ack(ack[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .break_det(brk[2]), .overrun(ovr[2]));

  uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)) u7o2 (
    .clk(clk), .reset_n(reset_n), .rx(rx[3]), .clk_en(clk_en), .data(data3),
    .valid(valid[3]), .rd_ack(ack[3]), .parity_err(perr[3]), .frame_err(ferr[3]),
    .break_det(brk[3]), .overrun(ovr[3]));

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Oversample tick every fourth clock, changed on the falling edge.
  always @(negedge clk) begin
    tickDiv = (tickDiv == 3) ? 0 : tickDiv + 1;
    clk_en = (tickDiv == 0);
  end

  // Count cycles spent with valid and overrun high per instance.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (valid[i] === 1'b1) validCycles[i]++;
      if (ovr[i] === 1'b1) ovrCycles[i]++;
    end
  end

  task automatic clearCounters();
    for (int i = 0; i < 4; i++) begin
      validCycles[i] = 0;
      ovrCycles[i] = 0;
    end
  endtask

  task automatic waitTick();
    @(posedge clk);
    while (!clk_en) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rx = 4'hF;
    ack = 4'h0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) waitTick();
    clearCounters();
  endtask

  task automatic sendBit(input int idx, input logic b);
    rx[idx] = b;
    repeat (16) waitTick();
  endtask

  // parBit < 0 means no parity bit; the commit happens on the 8th tick of
  // the final stop bit, and ackAtCommit raises rd_ack for exactly that cycle.
  task automatic sendFrame(input int idx, input logic [8:0] d, input int nb,
                           input int parBit, input logic [1:0] stops,
                           input int nStop, input bit ackAtCommit);
    waitTick();
    sendBit(idx, 1'b0);
    for (int i = 0; i < nb; i++) sendBit(idx, d[i]);
    if (parBit >= 0) sendBit(idx, parBit[0]);
    for (int s = 0; s < nStop - 1; s++) sendBit(idx, stops[s]);
    rx[idx] = stops[nStop-1];
    repeat (7) waitTick();
    if (ackAtCommit) begin
      repeat (3) @(posedge clk);
      #1 ack[idx] = 1'b1;
      @(posedge clk);
      #1 ack[idx] = 1'b0;
      repeat (8) waitTick();
    end else begin
      repeat (9) waitTick();
    end
    rx[idx] = 1'b1;
  endtask

  task automatic ackPulse(input int idx);
    ack[idx] = 1'b1;
    @(posedge clk);
    #1 ack[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #3;
    testsRun++;
    if (valid !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0000", valid); end
    testsRun++;
    if (data0 !== 8'h00 || data3 !== 7'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %h/%h expected 00/00", data0, data3); end
    testsRun++;
    if ({perr, ferr, brk, ovr} !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_flags: got %h expected 0000", {perr, ferr, brk, ovr}); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) waitTick();
    clearCounters();
  endtask

  task automatic test_basic();
    doReset();
    ack[0] = 1'b1;
    sendFrame(0, 9'h0A5, 8, -1, 2'b11, 1, 1'b0);
    repeat (4) waitTick();
    testsRun++;
    if (data0 !== 8'hA5) begin testsFailed++; $display("[TB] FAIL basic_data: got %h expected a5", data0); end
    testsRun++;
    if (validCycles[0] != 1) begin testsFailed++; $display("[TB] FAIL basic_valid_cycles: got %0d expected 1", validCycles[0]); end
    testsRun++;
    if ({perr[0], ferr[0], brk[0]} !== 3'b000) begin testsFailed++; $display("[TB] FAIL basic_flags: got %b expected 000", {perr[0], ferr[0], brk[0]}); end
    testsRun++;
    if (ovrCycles[0] != 0) begin testsFailed++; $display("[TB] FAIL basic_overrun: got %0d expected 0", ovrCycles[0]); end
    ack[0] = 1'b0;
  endtask

  task automatic test_parity();
    doReset();
    sendFrame(1, 9'h003, 8, 1, 2'b11, 1, 1'b0);
    sendFrame(2, 9'h003, 8, 1, 2'b11, 1, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data1 !== 8'h03 || valid[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL even_data: got %h v=%b expected 03 v=1", data1, valid[1]); end
    testsRun++;
    if (perr[1] !== 1'b1 || ferr[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL even_bad_parity: got p=%b f=%b expected p=1 f=0", perr[1], ferr[1]); end
    testsRun++;
    if (data2 !== 8'h03 || valid[2] !== 1'b1) begin testsFailed++; $display("[TB] FAIL odd_data: got %h v=%b expected 03 v=1", data2, valid[2]); end
    testsRun++;
    if (perr[2] !== 1'b0 || ferr[2] !== 1'b0) begin testsFailed++; $display("[TB] FAIL odd_good_parity: got p=%b f=%b expected p=0 f=0", perr[2], ferr[2]); end
    ackPulse(1);
    testsRun++;
    if (valid[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL even_ack_clear: got %b expected 0", valid[1]); end
    sendFrame(1, 9'h003, 8, 0, 2'b11, 1, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (perr[1] !== 1'b0 || valid[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL even_good_parity: got p=%b v=%b expected p=0 v=1", perr[1], valid[1]); end
  endtask

  task automatic test_frame_err();
    doReset();
    sendFrame(0, 9'h07E, 8, -1, 2'b00, 1, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data0 !== 8'h7E || ferr[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL frame_err_data: got %h f=%b expected 7e f=1", data0, ferr[0]); end
    testsRun++;
    if (brk[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_err_nobreak: got %b expected 0", brk[0]); end
    ackPulse(0);
    sendFrame(0, 9'h000, 8, -1, 2'b00, 1, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data0 !== 8'h00 || ferr[0] !== 1'b1 || valid[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL break_frame: got %h f=%b v=%b expected 00 f=1 v=1", data0, ferr[0], valid[0]); end
    testsRun++;
    if (brk[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL break_det: got %b expected 1", brk[0]); end
  endtask

  task automatic test_glitch();
    doReset();
    ack[0] = 1'b1;
    waitTick();
    rx[0] = 1'b0;
    repeat (6) waitTick();
    rx[0] = 1'b1;
    repeat (40) waitTick();
    testsRun++;
    if (validCycles[0] != 0) begin testsFailed++; $display("[TB] FAIL glitch_no_valid: got %0d expected 0", validCycles[0]); end
    sendFrame(0, 9'h055, 8, -1, 2'b11, 1, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data0 !== 8'h55 || validCycles[0] != 1) begin testsFailed++; $display("[TB] FAIL glitch_next_frame: got %h cycles=%0d expected 55 cycles=1", data0, validCycles[0]); end
    ack[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    doReset();
    sendFrame(0, 9'h011, 8, -1, 2'b11, 1, 1'b0);
    sendFrame(0, 9'h022, 8, -1, 2'b11, 1, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data0 !== 8'h11 || valid[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL overrun_keep: got %h v=%b expected 11 v=1", data0, valid[0]); end
    testsRun++;
    if (ovrCycles[0] != 1) begin testsFailed++; $display("[TB] FAIL overrun_pulse: got %0d expected 1", ovrCycles[0]); end
    doReset();
    sendFrame(0, 9'h011, 8, -1, 2'b11, 1, 1'b0);
    sendFrame(0, 9'h022, 8, -1, 2'b11, 1, 1'b1);
    repeat (2) waitTick();
    testsRun++;
    if (data0 !== 8'h22 || valid[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL ack_commit_load: got %h v=%b expected 22 v=1", data0, valid[0]); end
    testsRun++;
    if (ovrCycles[0] != 0) begin testsFailed++; $display("[TB] FAIL ack_commit_overrun: got %0d expected 0", ovrCycles[0]); end
  endtask

  task automatic test_7o2_reset();
    doReset();
    // 0x5A in 7 bits has four ones, so odd parity bit is 1.
    sendFrame(3, 9'h05A, 7, 1, 2'b01, 2, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data3 !== 7'h5A || valid[3] !== 1'b1) begin testsFailed++; $display("[TB] FAIL o2_data: got %h v=%b expected 5a v=1", data3, valid[3]); end
    testsRun++;
    if (ferr[3] !== 1'b1 || perr[3] !== 1'b0 || brk[3] !== 1'b0) begin testsFailed++; $display("[TB] FAIL o2_stop2_err: got f=%b p=%b b=%b expected f=1 p=0 b=0", ferr[3], perr[3], brk[3]); end
    waitTick();
    rx[3] = 1'b0;
    repeat (40) waitTick();
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (valid[3] !== 1'b0 || data3 !== 7'h00) begin testsFailed++; $display("[TB] FAIL o2_reset_outputs: got %h v=%b expected 00 v=0", data3, valid[3]); end
    testsRun++;
    if ({perr[3], ferr[3], brk[3], ovr[3]} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL o2_reset_flags: got %b expected 0000", {perr[3], ferr[3], brk[3], ovr[3]}); end
    rx[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    clearCounters();
    repeat (40) waitTick();
    testsRun++;
    if (validCycles[3] != 0) begin testsFailed++; $display("[TB] FAIL o2_no_spurious: got %0d expected 0", validCycles[3]); end
    // 0x2C in 7 bits has three ones, so odd parity bit is 0.
    sendFrame(3, 9'h02C, 7, 0, 2'b11, 2, 1'b0);
    repeat (2) waitTick();
    testsRun++;
    if (data3 !== 7'h2C || valid[3] !== 1'b1) begin testsFailed++; $display("[TB] FAIL o2_clean_data: got %h v=%b expected 2c v=1", data3, valid[3]); end
    testsRun++;
    if ({perr[3], ferr[3], brk[3]} !== 3'b000) begin testsFailed++; $display("[TB] FAIL o2_clean_flags: got %b expected 000", {perr[3], ferr[3], brk[3]}); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    clearCounters();
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_7o2_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
